// File: rtl/mem_io_bridge.sv
// Registered CPU-to-memory/IO bridge: RAM, BIOS read overlay and NUM_IO 8-bit
// peripheral slots, with per-region wait states, byte-lane steering and bus errors.
// Ports: clk, reset_n (async, active low); cpu_* request/ready side;
//   ram_* word-addressed RAM; bios_rdata (addressed by ram_addr); io_* peripheral slots.
// Optional: define MEMIO_TIMEOUT_EN to abort IO accesses without io_ack after TIMEOUT cycles.
// RAM/BIOS read data is sampled in the last ACCESS/WAIT cycle while ram_addr is presented.
module mem_io_bridge #(
    parameter int          ADDR_W    = 19,
    parameter int          NUM_IO    = 4,
    parameter int unsigned IO_BASE   = 32'h7FF00,
    parameter int          IO_SPAN_W = 3,
    parameter int          RAM_WAIT  = 0,
    parameter int          IO_WAIT   = 2,
    parameter int          BIOS_AW   = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [15:0]         cpu_wdata,
    output logic [15:0]         cpu_rdata,
    input  logic                cpu_we,
    input  logic                cpu_re,
    input  logic                cpu_be,
    output logic                cpu_ready,
    output logic                bus_err,
    input  logic                bios_e,
    output logic [ADDR_W-2:0]   ram_addr,
    output logic [15:0]         ram_wdata,
    input  logic [15:0]         ram_rdata,
    output logic [1:0]          ram_be,
    output logic                ram_we,
    input  logic [15:0]         bios_rdata,
    output logic [NUM_IO-1:0]   io_sel,
    output logic [IO_SPAN_W-1:0] io_addr,
    output logic [7:0]          io_wdata,
    input  logic [8*NUM_IO-1:0] io_rdata,
    output logic                io_we,
    output logic                io_re,
    input  logic                io_ack
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_e;

    localparam logic [1:0] K_RAM  = 2'd0;
    localparam logic [1:0] K_BIOS = 2'd1;
    localparam logic [1:0] K_IO   = 2'd2;
    localparam logic [1:0] K_ERR  = 2'd3;

    localparam int SLOT_W = 3;
`ifdef MEMIO_TIMEOUT_EN
    localparam int CW = 16;
`else
    localparam int CW = 3;
`endif

    localparam logic [ADDR_W:0] IOB      = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] WIN_LEN  = (ADDR_W+1)'(256);
    localparam logic [ADDR_W:0] IO_LEN   = (ADDR_W+1)'(NUM_IO << IO_SPAN_W);
    localparam logic [ADDR_W:0] BIOS_LEN = (ADDR_W+1)'(2 ** (BIOS_AW + 1));

    state_e                 state_q, state_d;
    logic [1:0]             kind_q, kind_d;
    logic                   we_q, we_d;
    logic                   byte_q, byte_d;
    logic                   lane_q, lane_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [15:0]            rdata_q, rdata_d;
    logic [ADDR_W-2:0]      ram_addr_q, ram_addr_d;
    logic [15:0]            ram_wdata_q, ram_wdata_d;
    logic [1:0]             ram_be_q, ram_be_d;
    logic [IO_SPAN_W-1:0]   io_addr_q, io_addr_d;
    logic [7:0]             io_wdata_q, io_wdata_d;

    logic [ADDR_W:0]        off;
    logic                   in_win, in_io, in_bios, misal;
    logic [1:0]             kind_dec;
    logic [CW-1:0]          need;
    logic                   fin, tmo, act;
    logic [7:0]             io_byte;
    logic [15:0]            src;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            kind_q      <= K_RAM;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 1'b0;
            slot_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_be_q    <= '0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            we_q        <= we_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_be_q    <= ram_be_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

    // Address decode; priority misaligned > IO slot > unmapped window > BIOS > RAM
    always_comb begin
        off     = {1'b0, cpu_addr} - IOB;
        in_win  = !off[ADDR_W] && (off < WIN_LEN);
        in_io   = !off[ADDR_W] && (off < IO_LEN);
        in_bios = bios_e && ({1'b0, cpu_addr} < BIOS_LEN);
        misal   = !cpu_be && cpu_addr[0];
        if (misal)                kind_dec = K_ERR;
        else if (in_io)           kind_dec = K_IO;
        else if (in_win)          kind_dec = K_ERR;
        else if (in_bios && !cpu_we) kind_dec = K_BIOS;
        else                      kind_dec = K_RAM;
    end

    // Completion conditions and read-data sources
    always_comb begin
        if (kind_q == K_IO)       need = CW'(IO_WAIT);
        else if (kind_q == K_ERR) need = '0;
        else                      need = CW'(RAM_WAIT);
        fin = (cnt_q >= need) && ((kind_q != K_IO) || io_ack);
`ifdef MEMIO_TIMEOUT_EN
        tmo = (kind_q == K_IO) && !fin && (cnt_q >= CW'(TIMEOUT - 1));
`else
        tmo = 1'b0;
`endif
        io_byte = '0;
        for (int k = 0; k < NUM_IO; k++) begin
            if (slot_q == SLOT_W'(k)) io_byte = io_rdata[8*k +: 8];
        end
        src = (kind_q == K_BIOS) ? bios_rdata : ram_rdata;
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        we_d        = we_q;
        byte_d      = byte_q;
        lane_d      = lane_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_be_d    = ram_be_q;
        io_addr_d   = io_addr_q;
        io_wdata_d  = io_wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_we || cpu_re) begin
                    state_d     = S_ACCESS;
                    kind_d      = kind_dec;
                    we_d        = cpu_we;
                    byte_d      = cpu_be;
                    lane_d      = cpu_addr[0];
                    slot_d      = off[IO_SPAN_W +: SLOT_W];
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    ram_addr_d  = cpu_addr[ADDR_W-1:1];
                    ram_wdata_d = cpu_be ? {2{cpu_wdata[7:0]}} : cpu_wdata;
                    ram_be_d    = !cpu_be ? 2'b11 :
                                  (cpu_addr[0] ? 2'b10 : 2'b01);
                    io_addr_d   = off[IO_SPAN_W-1:0];
                    io_wdata_d  = cpu_wdata[7:0];
                end
            end
            S_ACCESS, S_WAIT: begin
                if (tmo) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    rdata_d = 16'hFFFF;
                end else if (fin) begin
                    state_d = S_DONE;
                    err_d   = (kind_q == K_ERR);
                    if (we_q || kind_q == K_ERR) rdata_d = '0;
                    else if (kind_q == K_IO)     rdata_d = {8'h00, io_byte};
                    else if (byte_q)
                        rdata_d = {8'h00, lane_q ? src[15:8] : src[7:0]};
                    else                         rdata_d = src;
                end else begin
                    state_d = S_WAIT;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    // Outputs: strobes live from ACCESS through WAIT
    always_comb begin
        act       = (state_q == S_ACCESS) || (state_q == S_WAIT);
        ram_we    = act && we_q && (kind_q == K_RAM);
        io_we     = act && we_q && (kind_q == K_IO);
        io_re     = act && !we_q && (kind_q == K_IO);
        for (int k = 0; k < NUM_IO; k++) begin
            io_sel[k] = act && (kind_q == K_IO) && (slot_q == SLOT_W'(k));
        end
        cpu_ready = (state_q == S_DONE);
        bus_err   = (state_q == S_DONE) && err_q;
    end

    assign cpu_rdata = rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = ram_be_q;
    assign io_addr   = io_addr_q;
    assign io_wdata  = io_wdata_q;

endmodule
